sprite_table_writer: RTL
========================

Name: sprite_table_writer

Overview:
- Avalon-MM slave through which the CPU loads the 20-entry sprite table consumed by the VGA display top (the 512-bit gl_input bus plus its write strobe).
- CPU writes go into a shadow bank. A commit request copies the shadow bank to the active bank only at the next vertical-blank start, so sprites never tear mid-frame.
- Also provides a frame counter and an end-of-update interrupt for CPU frame pacing.

Parameters:
- NUM_ENTRIES, 20, number of sprite table entries.
- ENTRY_W, 24, bits per entry.
- OUT_W, 512, width of the packed output bus; bits above NUM_ENTRIES*ENTRY_W are tied to 0.

Ports:
- clk  in  1  system clock; the single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  5  word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- vblank_start  in  1  one-cycle pulse from display timing at the first blanked line.
- gl_output  out  OUT_W  active table, packed; entry i occupies bits [24i+23:24i]; bits 511:480 are 0.
- gl_write  out  1  one-cycle pulse when gl_output has just changed.
- irq  out  1  level interrupt, equal to irq_pending AND irq_en.

Behaviour:
- Reset: shadow and active banks cleared to 0; gl_output=0, gl_write=0, readdata=0, irq=0; commit_pending=0, irq_en=0, irq_pending=0, frame_count=0; FSM in IDLE.
- All accesses require chipselect=1; when chipselect=0, read and write are ignored. No waitrequest. Writes take effect at the clock edge. Read latency is 1 cycle; readdata holds its value when no read occurs.
- Address 0..19: write sets shadow[a] <= writedata[23:0], upper 8 bits ignored. Read returns {8'h00, shadow[a]}.
- Address 20 (CTRL):
  - Write: bit0=1 sets commit_pending (no effect if already set); irq_en <= bit1.
  - Read: {29'b0, irq_pending, irq_en, commit_pending}.
- Address 21 (STATUS):
  - Write: bit0=1 clears irq_pending.
  - Read: {16'b0, frame_count}.
- Address 22..31: writes are ignored; reads return 0.
- frame_count increments on every vblank_start, is 16 bits wide, and wraps from 0xFFFF to 0.
- FSM states:
  - IDLE: commit_pending=0.
  - ARMED: commit_pending=1, waiting for vblank.
  - UPDATE: one cycle.
- FSM transitions:
  - IDLE -> ARMED on a commit write.
  - ARMED -> UPDATE on vblank_start. At that edge: active <= shadow, gl_output takes the new value, commit_pending <= 0, irq_pending <= 1.
  - UPDATE: gl_write=1 for exactly this cycle. Next state is ARMED if a commit was written during UPDATE, otherwise IDLE.
- Latency: gl_output changes at the edge where vblank_start=1 is sampled; gl_write is high the following cycle.
- Boundary cases:
  - A commit write in the same cycle as vblank_start while IDLE latches commit_pending, but the swap waits for the next vblank_start.
  - A shadow write in the same cycle as the swap edge: active receives the pre-write shadow value; shadow keeps the new value.
  - An irq_pending clear in the same cycle as a swap: the set wins and irq_pending=1.
  - vblank_start during IDLE or UPDATE only increments frame_count.
  - Reset asserted mid-ARMED or mid-UPDATE returns everything to reset values with no gl_write pulse.

Test Plan:
- Reset, then read addresses 0, 20, 21, 25 -> readdata=0 each, one cycle after the read; gl_output=0; irq=0.
- Write 0xAB123456 to addr 3, read addr 3 -> 0x00123456; gl_output unchanged (0) with no vblank.
- Write addr 3, write CTRL=0x3, pulse vblank_start -> at that edge gl_output[95:72]=0x123456 and CTRL reads 0x6; next cycle gl_write=1 for one cycle; irq=1. Write STATUS=1 -> irq=0.
- Commit write in the same cycle as vblank_start from IDLE -> no swap; next vblank_start swaps; frame_count=2.
- Write addr 0 in the same cycle as the swapping vblank_start -> gl_output[23:0] holds the old shadow value; a second commit plus vblank delivers the new value.
- Preload frame_count to 0xFFFF by 65535 vblank pulses, pulse once more -> STATUS reads 0; assert reset while ARMED -> CTRL reads 0, gl_write never pulses.

Source files
------------

// File: rtl/sprite_table_writer.sv
// Avalon-MM loader for the display sprite table. CPU writes land in a shadow
// bank that is copied to the active bank at the next vertical blank.
module sprite_table_writer #(
  parameter int NUM_ENTRIES = 20,
  parameter int ENTRY_W     = 24,
  parameter int OUT_W       = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             vblank_start,
  output logic [OUT_W-1:0] gl_output,
  output logic             gl_write,
  output logic             irq
);

  localparam logic [4:0] CTRL_A   = 5'(NUM_ENTRIES);
  localparam logic [4:0] STATUS_A = 5'(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;

  state_t                                state_q, state_d;
  logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]   shadow_q, shadow_d;
  logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]   active_q, active_d;
  logic [31:0]                           readdata_q, readdata_d;
  logic [15:0]                           frame_count_q, frame_count_d;
  logic                                  irq_en_q, irq_en_d;
  logic                                  irq_pending_q, irq_pending_d;
  logic                                  wr_en, rd_en, commit_wr, swap, commit_pending;
  logic                                  unused_wdata;

  assign unused_wdata = ^writedata[31:ENTRY_W];

  assign wr_en          = chipselect & write;
  assign rd_en          = chipselect & read;
  assign commit_wr      = wr_en && (address == CTRL_A) && writedata[0];
  // A commit is pending exactly while armed; a commit written during UPDATE re-arms.
  assign commit_pending = (state_q == ARMED);
  assign swap           = commit_pending && vblank_start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit_wr) state_d = ARMED;
      ARMED:   if (vblank_start) state_d = UPDATE;
      UPDATE:  state_d = commit_wr ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    irq_en_d      = irq_en_q;
    irq_pending_d = irq_pending_q;
    frame_count_d = frame_count_q;
    readdata_d    = readdata_q;

    if (wr_en && (address < CTRL_A)) shadow_d[address] = writedata[ENTRY_W-1:0];
    if (wr_en && (address == CTRL_A)) irq_en_d = writedata[1];
    if (wr_en && (address == STATUS_A) && writedata[0]) irq_pending_d = 1'b0;
    // Swap samples the pre-write shadow and its irq set overrides a same-cycle clear.
    if (swap) begin
      active_d      = shadow_q;
      irq_pending_d = 1'b1;
    end
    if (vblank_start) frame_count_d = frame_count_q + 16'd1;

    if (rd_en) begin
      if (address < CTRL_A)
        readdata_d = {{(32-ENTRY_W){1'b0}}, shadow_q[address]};
      else if (address == CTRL_A)
        readdata_d = {29'd0, irq_pending_q, irq_en_q, commit_pending};
      else if (address == STATUS_A)
        readdata_d = {16'd0, frame_count_q};
      else
        readdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      readdata_q    <= '0;
      frame_count_q <= '0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      readdata_q    <= readdata_d;
      frame_count_q <= frame_count_d;
      irq_en_q      <= irq_en_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign readdata  = readdata_q;
  assign gl_output = OUT_W'(active_q);
  // Suppress the strobe if reset lands on the UPDATE cycle.
  assign gl_write  = (state_q == UPDATE) && !reset;
  assign irq       = irq_pending_q & irq_en_q;

endmodule
